// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program-counter stage for the fetch path.
// Holds the current PC, steps it by 4 (or 2 for compressed instructions),
// accepts redirects from the control/branch unit, traps misaligned
// redirect targets, and counts accepted advances.
//
// Handshake: there is no ready. advance is a consume strobe sampled on
// every rising edge. redirect_valid/redirect_target form a valid-only
// request that is also taken on the edge where it is seen. A redirect
// beats an advance in the same cycle, and that advance is dropped.
module pc_sequencer #(
  parameter int               WIDTH            = 32,
  parameter logic [WIDTH-1:0] RESET_PC         = '0,
  parameter bit               ALLOW_COMPRESSED = 1'b1,
  parameter int               COUNT_WIDTH      = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   advance,
  input  logic                   compressed,
  input  logic                   redirect_valid,
  input  logic [WIDTH-1:0]       redirect_target,
  output logic [WIDTH-1:0]       pc,
  output logic                   pc_valid,
  output logic                   fault,
  output logic [WIDTH-1:0]       fault_addr,
  output logic [COUNT_WIDTH-1:0] advance_count,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t                 r_state;
  logic [WIDTH-1:0]       r_pc;
  logic                   r_pc_valid;
  logic                   r_fault;
  logic [WIDTH-1:0]       r_fault_addr;
  logic [COUNT_WIDTH-1:0] r_count;

  logic [WIDTH-1:0]       w_step;
  logic [WIDTH-1:0]       w_pc_next;
  logic                   w_target_aligned;

  // Step size: compressed steps only exist when the ISA variant allows them.
  assign w_step = (ALLOW_COMPRESSED && compressed) ? WIDTH'(2) : WIDTH'(4);

  // Sequential PC; addition wraps naturally modulo 2^WIDTH.
  assign w_pc_next = r_pc + w_step;

  // Only redirects need checking: advances move an aligned PC by even steps.
  assign w_target_aligned = ALLOW_COMPRESSED ? ~redirect_target[0]
                                             : (redirect_target[1:0] == 2'b00);

  // Sequencer FSM with all outputs held in registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_pc_valid   <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
      r_count      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // One quiet cycle after reset before the PC is offered to fetch.
          r_state    <= S_RUN;
          r_pc_valid <= 1'b1;
        end

        S_RUN: begin
          if (redirect_valid) begin
            if (w_target_aligned) begin
              r_pc <= redirect_target;
            end else begin
              // Trap: keep the old PC, remember the bad target, stop fetch.
              r_fault      <= 1'b1;
              r_fault_addr <= redirect_target;
              r_pc_valid   <= 1'b0;
              r_state      <= S_FAULT;
            end
          end else if (advance) begin
            r_pc    <= w_pc_next;
            r_count <= r_count + COUNT_WIDTH'(1);
          end
        end

        S_FAULT: begin
          // Only a redirect can leave the trap; advances are ignored here.
          if (redirect_valid) begin
            if (w_target_aligned) begin
              r_pc       <= redirect_target;
              r_fault    <= 1'b0;
              r_pc_valid <= 1'b1;
              r_state    <= S_RUN;
            end else begin
              r_fault_addr <= redirect_target;
            end
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_pc_valid <= 1'b0;
        end
      endcase
    end
  end

  assign pc            = r_pc;
  assign pc_valid      = r_pc_valid;
  assign fault         = r_fault;
  assign fault_addr    = r_fault_addr;
  assign advance_count = r_count;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: two instances share one stimulus stream.
// u_dut0: compressed allowed, 32-bit count. u_dut1: 4-byte only, 4-bit count.
module tb_pc_sequencer;

  localparam int EW = 98;  // {pc[32], valid, fault, fault_addr[32], count[32]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        advance = 1'b0;
  logic        compressed = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;

  logic [31:0] pc0, fa0, cnt0;
  logic        v0, f0;
  logic [1:0]  st0;
  logic [31:0] pc1, fa1;
  logic [3:0]  cnt1;
  logic        v1, f1;
  logic [1:0]  st1;

  pc_sequencer #(.WIDTH(32), .RESET_PC(32'h100), .ALLOW_COMPRESSED(1'b1),
                 .COUNT_WIDTH(32)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .advance(advance), .compressed(compressed),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .pc(pc0), .pc_valid(v0), .fault(f0), .fault_addr(fa0),
    .advance_count(cnt0), .dbg_state(st0));

  pc_sequencer #(.WIDTH(32), .RESET_PC(32'h100), .ALLOW_COMPRESSED(1'b0),
                 .COUNT_WIDTH(4)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .advance(advance), .compressed(compressed),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .pc(pc1), .pc_valid(v1), .fault(f1), .fault_addr(fa1),
    .advance_count(cnt1), .dbg_state(st1));

  int total = 0;
  int bad = 0;

  // ---------------- reference model ----------------
  // Per-instance architectural view: started?, trapped?, pc, fault address, count.
  bit              m_ac[2] = '{1'b1, 1'b0};
  int              m_cw[2] = '{32, 4};
  bit              m_started[2];
  bit              m_trapped[2];
  logic [31:0]     m_pc[2];
  logic [31:0]     m_faddr[2];
  longint unsigned m_cnt[2];

  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];

  function automatic logic [EW-1:0] pack(logic [31:0] p, logic v, logic f,
                                          logic [31:0] fa, logic [31:0] c);
    return {p, v, f, fa, c};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_started[i] = 1'b0;
      m_trapped[i] = 1'b0;
      m_pc[i]      = 32'h100;
      m_faddr[i]   = 32'h0;
      m_cnt[i]     = 0;
    end
  endtask

  function automatic bit is_aligned(int i, logic [31:0] t);
    if (m_ac[i]) return (t % 2) == 0;
    return (t % 4) == 0;
  endfunction

  task automatic model_step(int i, bit adv, bit cmp, bit rv, logic [31:0] tgt);
    if (!m_started[i]) begin
      m_started[i] = 1'b1;
    end else if (rv) begin
      if (is_aligned(i, tgt)) begin
        m_pc[i]      = tgt;
        m_trapped[i] = 1'b0;
      end else begin
        m_trapped[i] = 1'b1;
        m_faddr[i]   = tgt;
      end
    end else if (adv && !m_trapped[i]) begin
      m_pc[i]  = m_pc[i] + ((m_ac[i] && cmp) ? 32'd2 : 32'd4);
      m_cnt[i] = (m_cnt[i] + 1) % (64'd1 << m_cw[i]);
    end
  endtask

  function automatic logic [EW-1:0] model_out(int i);
    return pack(m_pc[i], m_started[i] && !m_trapped[i], m_trapped[i],
                m_faddr[i], m_cnt[i][31:0]);
  endfunction

  // ---------------- driver ----------------
  task automatic cycle(bit adv, bit cmp, bit rv, logic [31:0] tgt);
    advance         = adv;
    compressed      = cmp;
    redirect_valid  = rv;
    redirect_target = tgt;
    for (int i = 0; i < 2; i++) model_step(i, adv, cmp, rv, tgt);
    exp_q0.push_back(model_out(0));
    exp_q1.push_back(model_out(1));
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] base;
    int          kind;
    base = $urandom & 32'hFFFF_FFFC;
    kind = $urandom_range(0, 9);
    case (kind)
      0: return base | 32'h1;
      1: return base | 32'h2;
      2: return base | 32'h3;
      3: return 32'hFFFF_FFF0 | ($urandom_range(0, 3) << 2);
      default: return base;
    endcase
  endfunction

  task automatic rand_cycles(int n);
    for (int k = 0; k < n; k++)
      cycle($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 6) == 0, rand_target());
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      a = pack(pc0, v0, f0, fa0, cnt0);
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL dut0 out: got pc=%h v=%b f=%b fa=%h cnt=%h expected pc=%h v=%b f=%b fa=%h cnt=%h",
                 a[97:66], a[65], a[64], a[63:32], a[31:0],
                 e[97:66], e[65], e[64], e[63:32], e[31:0]);
      end
    end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      a = pack(pc1, v1, f1, fa1, {28'b0, cnt1});
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL dut1 out: got pc=%h v=%b f=%b fa=%h cnt=%h expected pc=%h v=%b f=%b fa=%h cnt=%h",
                 a[97:66], a[65], a[64], a[63:32], a[31:0],
                 e[97:66], e[65], e[64], e[63:32], e[31:0]);
      end
    end
  end

  task automatic chk_reset_values(string tag);
    chk({tag, " pc0"}, pc0, 32'h100);
    chk({tag, " v0"}, {31'b0, v0}, 32'd0);
    chk({tag, " f0"}, {31'b0, f0}, 32'd0);
    chk({tag, " fa0"}, fa0, 32'd0);
    chk({tag, " cnt0"}, cnt0, 32'd0);
    chk({tag, " pc1"}, pc1, 32'h100);
    chk({tag, " f1"}, {31'b0, f1}, 32'd0);
    chk({tag, " cnt1"}, {28'b0, cnt1}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_values("por");
    #2 reset_n = 1'b1;
    chk("idle v0", {31'b0, v0}, 32'd0);

    // IDLE cycle, then three 4-byte advances.
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("first valid", {31'b0, v0}, 32'd1);
    chk("first pc", pc0, 32'h100);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("seq pc", pc0, 32'h10C);
    chk("seq cnt", cnt0, 32'd3);

    // Compressed pattern 1,0,1 from 0x200.
    cycle(1'b0, 1'b0, 1'b1, 32'h200);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("cmp pc0", pc0, 32'h208);
    chk("cmp pc1", pc1, 32'h20C);

    // Redirect wins over a simultaneous advance.
    cycle(1'b0, 1'b0, 1'b1, 32'h10);
    cycle(1'b1, 1'b0, 1'b1, 32'h80);
    chk("rdr pc", pc0, 32'h80);
    chk("rdr cnt", cnt0, 32'd6);

    // Misaligned redirect, ignored advance, second bad target, recovery.
    cycle(1'b0, 1'b0, 1'b1, 32'h83);
    chk("trap fa", fa0, 32'h83);
    chk("trap pc", pc0, 32'h80);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("trap adv pc", pc0, 32'h80);
    cycle(1'b0, 1'b0, 1'b1, 32'h41);
    chk("trap fa2", fa0, 32'h41);
    cycle(1'b1, 1'b0, 1'b1, 32'h1000);
    chk("recover pc", pc0, 32'h1000);
    chk("recover f", {31'b0, f0}, 32'd0);

    // 0x82 is fine with compressed steps but traps the 4-byte-only variant.
    cycle(1'b0, 1'b0, 1'b1, 32'h82);
    chk("half-aligned f0", {31'b0, f0}, 32'd0);
    chk("half-aligned f1", {31'b0, f1}, 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 32'h1000);

    // PC wrap and count wrap: count is 7 here, 17 more gives 24 (8 mod 16).
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap pc", pc0, 32'h0);
    chk("wrap f", {31'b0, f0}, 32'd0);
    repeat (17) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("cnt32", cnt0, 32'd24);
    chk("cnt4", {28'b0, cnt1}, 32'd8);

    rand_cycles(300);

    // Asynchronous reset while trapped.
    cycle(1'b0, 1'b0, 1'b1, 32'h83);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk_reset_values("async");
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values("held");
    @(negedge clk);
    #2 reset_n = 1'b1;
    chk("post idle v0", {31'b0, v0}, 32'd0);
    cycle(1'b1, 1'b0, 1'b1, 32'h3);
    chk("post valid", {31'b0, v0}, 32'd1);
    chk("post pc", pc0, 32'h100);
    rand_cycles(100);

    // Drain the scoreboard with a bounded wait.
    advance        = 1'b0;
    redirect_valid = 1'b0;
    for (int k = 0; k < 4 && (exp_q0.size() > 0 || exp_q1.size() > 0); k++)
      @(negedge clk);
    #1;
    total++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d/%0d pending expected 0", exp_q0.size(), exp_q1.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
